// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy state encoding and default bubble.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // All-zero instruction word, decoded downstream as a NOP.
    localparam logic [31:0] BUBBLE_NOP = 32'h0;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter adding 0..2 per cycle, sticks at all-ones; no backpressure, result visible next cycle.
module sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    // One extra bit catches overflow; cnt + 2 never exceeds 2^(CNT_W+1) - 1.
    logic [CNT_W:0] sum;

    assign sum = {1'b0, cnt} + (CNT_W + 1)'(inc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (sum[CNT_W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready, optional 2-entry skid, freeze and flush; 1-cycle latency.
// With SKID_EN the in_ready is registered (no combinational path from out_ready); otherwise it is combinational.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(BUBBLE_NOP),
    parameter bit                SKID_EN = 1'b1,
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              ready_q;
    logic              main_v;
    logic              skid_v;
    logic              in_fire;
    logic              out_fire;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;
    logic [1:0]        drop_n;

    assign main_v    = (state != ST_EMPTY);
    assign skid_v    = (state == ST_FULL);
    assign in_ready  = ~freeze & ~flush & (SKID_EN ? ready_q : (~main_v | out_ready));
    assign out_valid = main_v & ~freeze;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_d;
    assign occupancy = state;

    // Without the skid, ONE accepts only when draining, so FULL is never entered.
    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    next_state = ST_ONE;
                    load_main  = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    next_state = ST_FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    next_state     = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_EMPTY;
            main_d  <= BUBBLE;
            skid_d  <= BUBBLE;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= ST_EMPTY;
            main_d  <= BUBBLE;
            skid_d  <= BUBBLE;
            ready_q <= 1'b1;
        end else if (!freeze) begin
            state   <= next_state;
            ready_q <= (next_state != ST_FULL);
            if (load_main) begin
                main_d <= main_from_skid ? skid_d : in_data;
            end
            if (load_skid) begin
                skid_d <= in_data;
            end
        end
    end

    // Flush counts every valid beat it throws away, even when frozen.
    assign drop_n = flush ? ({1'b0, main_v} + {1'b0, skid_v}) : 2'd0;

    sat_cnt #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_n),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a skid instance (CNT_W=2) and a no-skid instance share stimulus.
module tb_pipe_stage_skid;

    localparam logic [15:0] BUB0 = 16'hB0B0;
    localparam logic [15:0] BUB1 = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        freeze;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        rdy  [2];
    logic        ovld [2];
    logic [15:0] odat [2];
    logic [1:0]  occ  [2];
    logic [1:0]  fcnt0;
    logic [7:0]  fcnt1;

    logic [15:0] exp_q [2][$];
    int          cnt_m [2];
    bit          bub   [2];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W (16), .BUBBLE (BUB0), .SKID_EN (1'b1), .CNT_W (2)
    ) u_dut_skid (
        .clk (clk), .rst (rst), .flush (flush), .freeze (freeze),
        .in_valid (in_valid), .in_ready (rdy[0]), .in_data (in_data),
        .out_valid (ovld[0]), .out_ready (out_ready), .out_data (odat[0]),
        .occupancy (occ[0]), .flush_cnt (fcnt0)
    );

    pipe_stage_skid #(
        .DATA_W (16), .SKID_EN (1'b0), .CNT_W (8)
    ) u_dut_flat (
        .clk (clk), .rst (rst), .flush (flush), .freeze (freeze),
        .in_valid (in_valid), .in_ready (rdy[1]), .in_data (in_data),
        .out_valid (ovld[1]), .out_ready (out_ready), .out_data (odat[1]),
        .occupancy (occ[1]), .flush_cnt (fcnt1)
    );

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", d, nm, act, expv, $time);
        end
    endtask

    // Output side: head of the expected queue must be presented; pop on a modelled transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    bit ev;
                    ev = (exp_q[i].size() > 0) && !freeze;
                    chk(i, "out_valid", ovld[i], ev);
                    if (exp_q[i].size() > 0) begin
                        chk(i, "out_data", odat[i], exp_q[i][0]);
                        if (ev && out_ready) void'(exp_q[i].pop_front());
                    end else if (bub[i]) begin
                        chk(i, "bubble", odat[i], (i == 0) ? BUB0 : BUB1);
                    end
                end
            end
        end
    end

    // Input side: drive one cycle, check acceptance against the queue model, then commit the model.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic ordy, input logic frz, input logic fl);
        bit fire [2];
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; out_ready = ordy; freeze = frz; flush = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            bit er;
            if (i == 0) er = !frz && !fl && (exp_q[i].size() < 2);
            else        er = !frz && !fl && ((exp_q[i].size() == 0) || ordy);
            fire[i] = v && er;
            if (r) begin
                chk(i, "in_ready", rdy[i], er);
                chk(i, "occupancy", occ[i], exp_q[i].size());
                chk(i, "flush_cnt", (i == 0) ? {30'b0, fcnt0} : {24'b0, fcnt1}, cnt_m[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            int mx;
            mx = (i == 0) ? 3 : 255;
            if (!r) begin
                exp_q[i].delete();
                cnt_m[i] = 0;
                bub[i] = 1'b1;
            end else if (fl) begin
                cnt_m[i] = (cnt_m[i] + exp_q[i].size() > mx) ? mx : cnt_m[i] + exp_q[i].size();
                exp_q[i].delete();
                bub[i] = 1'b1;
            end else if (fire[i]) begin
                exp_q[i].push_back(d);
                bub[i] = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt_m[i] = 0;
            bub[i] = 1'b1;
        end

        // Reset held two cycles with a valid beat offered, then streaming.
        step(0, 1, 16'h0055, 1, 0, 0);
        step(0, 1, 16'h0055, 1, 0, 0);
        step(1, 1, 16'h0011, 1, 0, 0);
        step(1, 1, 16'h0022, 1, 0, 0);
        step(1, 1, 16'h0033, 1, 0, 0);
        step(1, 0, 16'h0000, 1, 0, 0);

        // Skid fill and drain.
        step(1, 1, 16'h00A1, 0, 0, 0);
        step(1, 1, 16'h00A2, 0, 0, 0);
        step(1, 0, 16'h0000, 0, 0, 0);
        repeat (3) step(1, 0, 16'h0000, 1, 0, 0);

        // Freeze while full, then release.
        step(1, 1, 16'h00A1, 0, 0, 0);
        step(1, 1, 16'h00A2, 0, 0, 0);
        repeat (3) step(1, 1, 16'h00F0, 1, 1, 0);
        repeat (2) step(1, 0, 16'h0000, 1, 0, 0);

        // Flush while full and frozen, with an incoming beat that must be dropped.
        step(1, 1, 16'h00B1, 0, 0, 0);
        step(1, 1, 16'h00B2, 0, 0, 0);
        step(1, 1, 16'h00EE, 1, 1, 1);
        repeat (2) step(1, 0, 16'h0000, 1, 0, 0);

        // Repeated flushes to drive the 2-bit counter into saturation.
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 16'h00C0 + 16'(k), 0, 0, 0);
            step(1, 1, 16'h00D0 + 16'(k), 0, 0, 0);
            step(1, 0, 16'h0000, 0, 0, 1);
        end
        step(1, 0, 16'h0000, 1, 0, 0);

        // Random traffic with occasional freeze, flush and reset.
        for (int k = 0; k < 600; k++) begin
            logic r, v, o, fz, fl;
            r  = ($urandom_range(0, 63) != 0);
            v  = ($urandom_range(0, 3) != 0);
            o  = ($urandom_range(0, 2) != 0);
            fz = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 15) == 0);
            if (fl && !fz) o = 1'b0;
            step(r, v, 16'($urandom), o, fz, fl);
        end
        repeat (4) step(1, 0, 16'h0000, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
